// File: rtl/uart_rx.sv
// Oversampling UART receiver with optional parity check and stop-bit validation.
// Define UART_RX_MAJORITY_VOTE_EN to decide each bit by 2-of-3 majority around mid-bit.
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] PRESCALE,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

  state_t                  state;
  logic [PRESCALE_W-1:0]   n;
  logic [PRESCALE_W-1:0]   n_sel;
  logic [PRESCALE_W-1:0]   cnt;
  logic [PRESCALE_W-1:0]   half;
  logic [PRESCALE_W-1:0]   dec;
  logic [PRESCALE_W-1:0]   last;
  logic [BIT_W-1:0]        bit_idx;
  logic [DATA_WIDTH-1:0]   shreg;
  logic                    par_en_q;
  logic                    par_typ_q;
  logic                    par_bad;
  logic                    s_mid;
  logic                    bit_val;
`ifdef UART_RX_MAJORITY_VOTE_EN
  logic                    s_early;
`endif

  always_comb begin
    n_sel = PRESCALE_W'(8);
    if (PRESCALE == PRESCALE_W'(8) || PRESCALE == PRESCALE_W'(16) ||
        PRESCALE == PRESCALE_W'(32))
      n_sel = PRESCALE;
  end

  assign half = n >> 1;
  assign dec  = half + PRESCALE_W'(1);
  assign last = n - PRESCALE_W'(1);

  // The third vote is the live line at the decision edge, so the decision
  // lands on the same edge as in single-sample mode.
  always_comb begin
`ifdef UART_RX_MAJORITY_VOTE_EN
    bit_val = (s_early & s_mid) | (s_early & RX_IN) | (s_mid & RX_IN);
`else
    bit_val = s_mid;
`endif
  end

  always_ff @(posedge CLK) begin
    DATA_VALID <= 1'b0;
    PAR_ERR    <= 1'b0;
    STP_ERR    <= 1'b0;
    if (RST) begin
      state     <= IDLE;
      n         <= PRESCALE_W'(8);
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_bad   <= 1'b0;
      s_mid     <= 1'b0;
`ifdef UART_RX_MAJORITY_VOTE_EN
      s_early   <= 1'b0;
`endif
      P_DATA    <= '0;
    end else begin
      if (state != IDLE && state != DONE) begin
        cnt <= (cnt == last) ? '0 : cnt + PRESCALE_W'(1);
        if (cnt == half) s_mid <= RX_IN;
`ifdef UART_RX_MAJORITY_VOTE_EN
        if (cnt == half - PRESCALE_W'(1)) s_early <= RX_IN;
`endif
      end
      case (state)
        IDLE: begin
          // The detecting cycle is edge 0 of the start bit.
          if (!RX_IN) begin
            state     <= START;
            cnt       <= PRESCALE_W'(1);
            n         <= n_sel;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
            par_bad   <= 1'b0;
            bit_idx   <= '0;
          end
        end
        START: begin
          if (cnt == dec && bit_val) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == last) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (cnt == dec) shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
          if (cnt == last) begin
            if (bit_idx == BIT_W'(DATA_WIDTH - 1)) begin
              bit_idx <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_idx <= bit_idx + BIT_W'(1);
            end
          end
        end
        PARITY: begin
          if (cnt == dec) par_bad <= (bit_val != ((^shreg) ^ par_typ_q));
          if (cnt == last) state <= STOP;
        end
        STOP: begin
          // Outputs are registered here so they are high during DONE.
          if (cnt == dec) begin
            state <= DONE;
            cnt   <= '0;
            if (bit_val && !par_bad) begin
              P_DATA     <= shreg;
              DATA_VALID <= 1'b1;
            end else begin
              PAR_ERR <= par_bad;
              STP_ERR <= ~bit_val;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: framing, parity, stop errors,
// glitch rejection, mid-frame reset and back-to-back frames.
module tb_uart_rx;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic [5:0] PRESCALE = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dv_cnt = 0;
  int pe_cnt = 0;
  int se_cnt = 0;
  int dv_cyc = 0;
  int pdata_jumps = 0;
  logic [7:0] prev_pdata = 8'h00;
  logic rst_d = 1'b1;

  uart_rx #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
    .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR), .STP_ERR(STP_ERR)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc   <= cyc + 1;
    rst_d <= RST;
  end

  always @(negedge CLK) begin
    if (DATA_VALID === 1'b1) begin
      dv_cnt = dv_cnt + 1;
      dv_cyc = cyc;
    end
    if (PAR_ERR === 1'b1) pe_cnt = pe_cnt + 1;
    if (STP_ERR === 1'b1) se_cnt = se_cnt + 1;
    if (!rst_d && !$isunknown(P_DATA) && P_DATA !== prev_pdata && DATA_VALID !== 1'b1)
      pdata_jumps = pdata_jumps + 1;
    prev_pdata = P_DATA;
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic drive_bit(input logic v, input int n);
    RX_IN = v;
    tick(n);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [5:0] presc, input int n,
                            input logic pe, input logic pt, input logic pbit,
                            input logic sbit, input int glitch_bit, output int stop_cyc);
    PRESCALE = presc;
    PAR_EN   = pe;
    PAR_TYP  = pt;
    drive_bit(1'b0, n);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        RX_IN = d[i];
        tick(n / 2);
        RX_IN = ~d[i];
        tick(1);
        RX_IN = d[i];
        tick(n / 2 - 1);
      end else begin
        drive_bit(d[i], n);
      end
    end
    if (pe) drive_bit(pbit, n);
    stop_cyc = cyc;
    drive_bit(sbit, n);
    RX_IN = 1'b1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick(3);
    checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL reset_pdata got %h want 00", P_DATA); end
    checks++; if (DATA_VALID !== 1'b0) begin errors++; $display("FAIL reset_dv got %b want 0", DATA_VALID); end
    checks++; if (PAR_ERR !== 1'b0) begin errors++; $display("FAIL reset_pe got %b want 0", PAR_ERR); end
    checks++; if (STP_ERR !== 1'b0) begin errors++; $display("FAIL reset_se got %b want 0", STP_ERR); end
    RST = 1'b0;
    tick(2);
  endtask

  task automatic test_parity_odd_ok();
    int dv0, pe0, se0, sc;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    send_frame(8'hA8, 6'd8, 8, 1'b1, 1'b1, 1'b0, 1'b1, -1, sc);
    tick(4);
    checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL odd_dv_pulses got %0d want 1", dv_cnt - dv0); end
    checks++; if (pe_cnt - pe0 !== 0) begin errors++; $display("FAIL odd_pe_pulses got %0d want 0", pe_cnt - pe0); end
    checks++; if (se_cnt - se0 !== 0) begin errors++; $display("FAIL odd_se_pulses got %0d want 0", se_cnt - se0); end
    checks++; if (P_DATA !== 8'hA8) begin errors++; $display("FAIL odd_pdata got %h want a8", P_DATA); end
    checks++; if (dv_cyc !== sc + 6) begin errors++; $display("FAIL odd_latency got %0d want %0d", dv_cyc, sc + 6); end
  endtask

  task automatic test_parity_err();
    int dv0, pe0, se0, sc;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    send_frame(8'h54, 6'd16, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1, sc);
    tick(4);
    checks++; if (pe_cnt - pe0 !== 1) begin errors++; $display("FAIL perr_pe_pulses got %0d want 1", pe_cnt - pe0); end
    checks++; if (dv_cnt - dv0 !== 0) begin errors++; $display("FAIL perr_dv_pulses got %0d want 0", dv_cnt - dv0); end
    checks++; if (se_cnt - se0 !== 0) begin errors++; $display("FAIL perr_se_pulses got %0d want 0", se_cnt - se0); end
    checks++; if (P_DATA !== 8'hA8) begin errors++; $display("FAIL perr_pdata got %h want a8", P_DATA); end
  endtask

  task automatic test_back_to_back();
    int dv0, pe0, se0, sc;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    send_frame(8'hCA, 6'd32, 32, 1'b0, 1'b0, 1'b0, 1'b0, -1, sc);
    checks++; if (se_cnt - se0 !== 1) begin errors++; $display("FAIL stp_se_pulses got %0d want 1", se_cnt - se0); end
    checks++; if (dv_cnt - dv0 !== 0) begin errors++; $display("FAIL stp_dv_pulses got %0d want 0", dv_cnt - dv0); end
    checks++; if (P_DATA !== 8'hA8) begin errors++; $display("FAIL stp_pdata got %h want a8", P_DATA); end
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    send_frame(8'h35, 6'd32, 32, 1'b0, 1'b0, 1'b0, 1'b1, -1, sc);
    tick(4);
    checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL b2b_dv_pulses got %0d want 1", dv_cnt - dv0); end
    checks++; if (P_DATA !== 8'h35) begin errors++; $display("FAIL b2b_pdata got %h want 35", P_DATA); end
    checks++; if ((pe_cnt - pe0) + (se_cnt - se0) !== 0) begin errors++; $display("FAIL b2b_err_pulses got %0d want 0", (pe_cnt - pe0) + (se_cnt - se0)); end
  endtask

  task automatic test_start_glitch();
    int dv0, pe0, se0, sc;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    PRESCALE = 6'd8;
    PAR_EN = 1'b0;
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 24);
    checks++; if (dv_cnt - dv0 !== 0) begin errors++; $display("FAIL glitch_dv_pulses got %0d want 0", dv_cnt - dv0); end
    checks++; if ((pe_cnt - pe0) + (se_cnt - se0) !== 0) begin errors++; $display("FAIL glitch_err_pulses got %0d want 0", (pe_cnt - pe0) + (se_cnt - se0)); end
    checks++; if (P_DATA !== 8'h35) begin errors++; $display("FAIL glitch_pdata got %h want 35", P_DATA); end
    // Illegal prescale 12 must behave as 8 cycles per bit.
    dv0 = dv_cnt;
    send_frame(8'h3C, 6'd12, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, sc);
    tick(4);
    checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL illegal_n_dv got %0d want 1", dv_cnt - dv0); end
    checks++; if (P_DATA !== 8'h3C) begin errors++; $display("FAIL illegal_n_pdata got %h want 3c", P_DATA); end
    checks++; if (dv_cyc !== sc + 6) begin errors++; $display("FAIL illegal_n_latency got %0d want %0d", dv_cyc, sc + 6); end
  endtask

  task automatic test_data_glitch();
    int dv0, sc;
    logic [7:0] want;
`ifdef UART_RX_MAJORITY_VOTE_EN
    want = 8'h0F;
`else
    want = 8'h07;
`endif
    dv0 = dv_cnt;
    send_frame(8'h0F, 6'd16, 16, 1'b0, 1'b0, 1'b0, 1'b1, 3, sc);
    tick(4);
    checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL dglitch_dv got %0d want 1", dv_cnt - dv0); end
    checks++; if (P_DATA !== want) begin errors++; $display("FAIL dglitch_pdata got %h want %h", P_DATA, want); end
  endtask

  task automatic test_reset_mid_frame();
    int dv0, pe0, se0, sc;
    dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
    PRESCALE = 6'd8;
    PAR_EN = 1'b0;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 8);
    drive_bit(1'b1, 3);
    RST = 1'b1;
    tick(1);
    RST = 1'b0;
    checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL mrst_pdata got %h want 00", P_DATA); end
    checks++; if ({DATA_VALID, PAR_ERR, STP_ERR} !== 3'b000) begin errors++; $display("FAIL mrst_flags got %b want 000", {DATA_VALID, PAR_ERR, STP_ERR}); end
    drive_bit(1'b1, 40);
    checks++; if (dv_cnt - dv0 !== 0) begin errors++; $display("FAIL mrst_dv_pulses got %0d want 0", dv_cnt - dv0); end
    checks++; if ((pe_cnt - pe0) + (se_cnt - se0) !== 0) begin errors++; $display("FAIL mrst_err_pulses got %0d want 0", (pe_cnt - pe0) + (se_cnt - se0)); end
    send_frame(8'h81, 6'd8, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, sc);
    tick(4);
    checks++; if (dv_cnt - dv0 !== 1) begin errors++; $display("FAIL mrst_next_dv got %0d want 1", dv_cnt - dv0); end
    checks++; if (P_DATA !== 8'h81) begin errors++; $display("FAIL mrst_next_pdata got %h want 81", P_DATA); end
  endtask

  task automatic test_pdata_stable();
    checks++; if (pdata_jumps !== 0) begin errors++; $display("FAIL pdata_stable got %0d unexpected changes want 0", pdata_jumps); end
  endtask

  initial begin
    tick(1);
    test_reset();
    test_parity_odd_ok();
    test_parity_err();
    test_back_to_back();
    test_start_glitch();
    test_data_glitch();
    test_reset_mid_frame();
    test_pdata_stable();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: DATA_WIDTH, 8, number of data bits per frame, sent LSB first.
REQ-002 Parameter: PRESCALE_W, 6, width of the PRESCALE port.
REQ-003 Port: CLK  input  1  single clock for all logic; oversampling clock, one tick per CLK cycle.
REQ-004 Port: RST  input  1  synchronous, active-high reset.
REQ-005 Port: RX_IN  input  1  serial line; idles high; already synchronized upstream.
REQ-006 Port: PRESCALE  input  PRESCALE_W  CLK cycles per bit; legal values 8, 16 and 32.
REQ-007 Port: PAR_EN  input  1  1 means a parity bit follows the data bits.
REQ-008 Port: PAR_TYP  input  1  parity type: 0 = even, 1 = odd.
REQ-009 Port: P_DATA  output  DATA_WIDTH  last correctly received byte.
REQ-010 Port: DATA_VALID  output  1  one-cycle pulse when P_DATA is updated.
REQ-011 Port: PAR_ERR  output  1  one-cycle pulse when a frame fails the parity check.
REQ-012 Port: STP_ERR  output  1  one-cycle pulse when a frame has a bad stop bit.

Function
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PARITY, STOP and DONE.
REQ-014 Bit timing and frame configuration:
- N = PRESCALE; any illegal value SHALL be treated as 8.
- PRESCALE, PAR_EN and PAR_TYP SHALL be captured on the IDLE->START transition.
- The captured values SHALL be held for the whole frame.
REQ-015 Start detection:
- In IDLE, a 0 on RX_IN SHALL move the FSM to START.
- That cycle SHALL count as edge 0 of the start bit.
REQ-016 A cycle counter SHALL count edges 0..N-1 per bit, then wrap to 0 and advance the bit position.
REQ-017 Sampling:
- Each bit SHALL be sampled at edge N/2 (single-sample mode).
- The bit value SHALL be decided at edge N/2+1.
REQ-018 Start-bit glitch: if the decided start bit is 1, the FSM SHALL return to IDLE with no output pulse.
REQ-019 DATA:
- Exactly DATA_WIDTH bits SHALL be shifted in, LSB first.
- Then the FSM SHALL go to PARITY if the captured PAR_EN=1, else to STOP.
REQ-020 PARITY check: the received parity bit SHALL equal the XOR of the data bits, inverted when the captured PAR_TYP=1.
REQ-021 STOP check: the stop bit SHALL be decided as 1; a decided 0 is a stop error.
REQ-022 After the stop-bit decision the FSM SHALL enter DONE for exactly one cycle, then return to IDLE. A 0 on RX_IN seen in that IDLE cycle starts the next frame back-to-back.
REQ-023 In DONE, if there is no parity error and no stop error:
- P_DATA SHALL load the shifted byte.
- DATA_VALID SHALL pulse for one cycle.
REQ-024 In DONE, if there is an error:
- PAR_ERR and/or STP_ERR SHALL pulse for one cycle.
- DATA_VALID SHALL stay 0 and P_DATA SHALL hold its old value.
- Both error flags SHALL pulse together when both errors occur.
REQ-025 Latency: DATA_VALID SHALL rise in the cycle after the edge-(N/2+1) decision of the stop bit.
REQ-026 P_DATA SHALL be stable between DATA_VALID pulses.
REQ-027 RX_IN SHALL be ignored outside the sample points, except for start detection in IDLE.

Reset
REQ-028 While RST=1 at a CLK edge, the block SHALL:
- go to IDLE and clear the counters and the shift register;
- drive P_DATA=0, DATA_VALID=0, PAR_ERR=0 and STP_ERR=0.
REQ-029 A reset during a frame SHALL abort it with no output pulse. Reception SHALL resume with the first falling edge after RST drops.
REQ-030 Reset SHALL take effect only at a CLK edge; there SHALL be no asynchronous path.

Configuration
REQ-031 The macro UART_RX_MAJORITY_VOTE_EN SHALL select the sampling mode.
- Defined: each bit is sampled at edges N/2-1, N/2 and N/2+1, and the bit value is the 2-of-3 majority, decided at edge N/2+1.
- Undefined: single sample at edge N/2, as in REQ-017.
- Decision timing and latency SHALL be the same in both modes.

Verification
REQ-032 N=8, PAR_EN=1, PAR_TYP=1, frame byte 0xA8 with parity bit 0 -> P_DATA=0xA8 and one DATA_VALID pulse 1 cycle after the stop decision; no error pulses.
REQ-033 N=16, PAR_EN=1, PAR_TYP=0, byte 0x54 sent with wrong parity bit 0 -> one PAR_ERR pulse; no DATA_VALID pulse; P_DATA unchanged.
REQ-034 N=32, PAR_EN=0, byte 0xCA with stop bit 0 -> one STP_ERR pulse; no DATA_VALID pulse. A following frame of 0x35 sent back-to-back -> DATA_VALID pulse with P_DATA=0x35.
REQ-035 N=8, RX_IN low for 2 cycles then high -> return to IDLE; no output activity.
REQ-036 Macro defined: N=16, a 1-cycle inverted pulse at edge N/2 of data bit 3 of 0x0F -> P_DATA=0x0F. Macro undefined, same stimulus -> P_DATA=0x07.
REQ-037 RST asserted for 1 cycle during data bit 4 -> all outputs 0, no pulse for that frame; the next full frame 0x81 is received correctly.
